// File: rtl/hwpf_issuer_if.sv
// Prefetch-queue pop and HPDcache request/response signals seen by the prefetch issuer.
interface hwpf_issuer_if #(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned TID_W  = 7
);
    logic              fifo_read;
    logic              fifo_valid;
    logic [ADDR_W-1:0] fifo_addr;
    logic              dcache_req_valid;
    logic              dcache_req_ready;
    logic [ADDR_W-1:0] dcache_req_addr;
    logic [TID_W-1:0]  dcache_req_tid;
    logic              dcache_rsp_valid;
    logic [TID_W-1:0]  dcache_rsp_tid;

    // Issuer side
    modport master (
        output fifo_read, dcache_req_valid, dcache_req_addr, dcache_req_tid,
        input  fifo_valid, fifo_addr, dcache_req_ready, dcache_rsp_valid, dcache_rsp_tid
    );

    // Queue / cache side
    modport slave (
        input  fifo_read, dcache_req_valid, dcache_req_addr, dcache_req_tid,
        output fifo_valid, fifo_addr, dcache_req_ready, dcache_rsp_valid, dcache_rsp_tid
    );
endinterface

// File: rtl/hwpf_issuer.sv
// Next-line prefetch issuer: pops the prefetch queue, filters in-flight duplicates,
// allocates a prefetch TID slot and issues line-aligned requests to the HPDcache.
module hwpf_issuer #(
    parameter int unsigned      MAX_INFLIGHT = 4,
    parameter int unsigned      ADDR_W       = 40,
    parameter int unsigned      LINE_BYTES   = 64,
    parameter int unsigned      TID_W        = 7,
    parameter logic [TID_W-1:0] TID_BASE     = 7'h40
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          lock_i,
    hwpf_issuer_if.master                 bus,
    output logic                          drop_o,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt_o,
    output logic                          busy_o
);
    localparam int unsigned SLOT_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W  = SLOT_W + 1;
    localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned LINE_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {IDLE, POP, WAIT, ISSUE} state_e;

    state_e                  state_q, state_d;
    logic [MAX_INFLIGHT-1:0] slot_valid_q, slot_valid_d;
    logic [LINE_W-1:0]       slot_line_q [MAX_INFLIGHT];
    logic [LINE_W-1:0]       req_line_q;
    logic [SLOT_W-1:0]       req_slot_q;
    logic [TID_W-1:0]        req_tid_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [LINE_W-1:0] fifo_line;
    logic [SLOT_W-1:0] free_slot;
    logic [SLOT_W-1:0] rsp_slot;
    logic              dup_hit;
    logic              slot_full;
    logic              handshake;
    logic              rsp_hit;

    assign fifo_line = bus.fifo_addr[ADDR_W-1:OFF_W];
    assign slot_full = &slot_valid_q;
    assign handshake = (state_q == ISSUE) && bus.dcache_req_ready;
    assign rsp_slot  = bus.dcache_rsp_tid[SLOT_W-1:0];
    // TID_BASE is slot-count aligned, so the upper TID bits identify a prefetch response
    assign rsp_hit   = bus.dcache_rsp_valid
                     && (bus.dcache_rsp_tid[TID_W-1:SLOT_W] == TID_BASE[TID_W-1:SLOT_W])
                     && slot_valid_q[rsp_slot];

    // Lowest free slot and duplicate-line lookup
    always_comb begin
        dup_hit   = 1'b0;
        free_slot = '0;
        for (int i = int'(MAX_INFLIGHT) - 1; i >= 0; i--) begin
            if (!slot_valid_q[i]) begin
                free_slot = SLOT_W'(i);
            end
            if (slot_valid_q[i] && (slot_line_q[i] == fifo_line)) begin
                dup_hit = 1'b1;
            end
        end
    end

    // Slot occupancy update; the reserved slot is never valid, so free and allocate cannot collide
    always_comb begin
        slot_valid_d = slot_valid_q;
        if (rsp_hit) begin
            slot_valid_d[rsp_slot] = 1'b0;
        end
        if (handshake) begin
            slot_valid_d[req_slot_q] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
            cnt_d = cnt_d + CNT_W'(slot_valid_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!lock_i && !flush_i && !slot_full) state_d = POP;
            POP:     state_d = flush_i ? IDLE : WAIT;
            WAIT:    state_d = (flush_i || !bus.fifo_valid || dup_hit) ? IDLE : ISSUE;
            ISSUE:   if (handshake || flush_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            cnt_q        <= '0;
            req_line_q   <= '0;
            req_slot_q   <= '0;
            req_tid_q    <= '0;
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                slot_line_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            cnt_q        <= cnt_d;
            if (handshake) begin
                slot_line_q[req_slot_q] <= req_line_q;
            end
            if ((state_q == WAIT) && (state_d == ISSUE)) begin
                req_line_q <= fifo_line;
                req_slot_q <= free_slot;
                req_tid_q  <= TID_BASE + TID_W'(free_slot);
            end
        end
    end

    always_comb begin
        bus.fifo_read        = (state_q == POP);
        bus.dcache_req_valid = (state_q == ISSUE);
        bus.dcache_req_addr  = {req_line_q, OFF_W'(0)};
        bus.dcache_req_tid   = req_tid_q;
        drop_o               = (state_q == WAIT) && bus.fifo_valid && dup_hit && !flush_i;
        busy_o               = (state_q != IDLE);
        inflight_cnt_o       = cnt_q;
    end
endmodule

// File: tb/tb_hwpf_issuer.sv
// Self-checking bench for hwpf_issuer: a queue/cache environment plus a slot-level
// reference model checked every cycle, followed by directed and randomized scenarios.
module tb_hwpf_issuer;
    localparam int unsigned     MAXI    = 4;
    localparam int unsigned     AW      = 40;
    localparam int unsigned     TW      = 7;
    localparam int unsigned     LB      = 64;
    localparam logic [TW-1:0]   TB_BASE = 7'h40;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       lock_i;
    logic       drop_o;
    logic       busy_o;
    logic [2:0] inflight_cnt_o;

    hwpf_issuer_if #(.ADDR_W(AW), .TID_W(TW)) bus ();

    hwpf_issuer #(
        .MAX_INFLIGHT(MAXI), .ADDR_W(AW), .LINE_BYTES(LB), .TID_W(TW), .TID_BASE(TB_BASE)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .lock_i(lock_i), .bus(bus),
        .drop_o(drop_o), .inflight_cnt_o(inflight_cnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_checks;
    int            n_fail;
    int            n_issue;
    int            n_drop;
    int            n_read;
    logic [AW-1:0] q_addr [$];
    bit            mv [MAXI];
    logic [AW-1:0] mline [MAXI];
    bit            in_wait;
    bit            pend_v;
    logic [AW-1:0] pend_addr;
    logic [TW-1:0] pend_tid;
    logic [TW-1:0] last_tid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < int'(MAXI); i++) c += int'(mv[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(MAXI); i++) begin
            mv[i]    = 1'b0;
            mline[i] = '0;
        end
        in_wait = 1'b0;
        pend_v  = 1'b0;
        q_addr.delete();
    endtask

    // One clock: check the current cycle at negedge, advance the model, then drive the queue output.
    task automatic tick();
        logic          rd;
        logic          hs;
        logic          exp_drop;
        logic          new_pend;
        logic [AW-1:0] line_a;
        int            free_i;
        int            t;
        @(negedge clk_i);
        chk("inflight_cnt", 64'(inflight_cnt_o), 64'(model_cnt()));
        chk("req_valid", 64'(bus.dcache_req_valid), 64'(pend_v));
        if (pend_v) begin
            chk("req_addr", 64'(bus.dcache_req_addr), 64'(pend_addr));
            chk("req_tid", 64'(bus.dcache_req_tid), 64'(pend_tid));
        end
        exp_drop = 1'b0;
        new_pend = 1'b0;
        line_a   = '0;
        free_i   = -1;
        if (in_wait && !flush_i && bus.fifo_valid) begin
            line_a = bus.fifo_addr - (bus.fifo_addr % AW'(LB));
            for (int i = 0; i < int'(MAXI); i++) begin
                if (mv[i] && (mline[i] == line_a)) exp_drop = 1'b1;
            end
            if (!exp_drop) begin
                for (int i = int'(MAXI) - 1; i >= 0; i--) begin
                    if (!mv[i]) free_i = i;
                end
                chk("free_slot_exists", 64'(free_i >= 0), 64'(1));
                new_pend = 1'b1;
            end
        end
        chk("drop", 64'(drop_o), 64'(exp_drop));
        if (model_cnt() == int'(MAXI)) chk("no_pop_when_full", 64'(bus.fifo_read), 64'(0));
        if (drop_o === 1'b1) n_drop++;
        if (bus.fifo_read === 1'b1) n_read++;
        rd = bus.fifo_read;
        hs = pend_v && bus.dcache_req_ready;
        t  = int'(bus.dcache_rsp_tid) - int'(TB_BASE);
        if (bus.dcache_rsp_valid && t >= 0 && t < int'(MAXI)) begin
            if (mv[t]) mv[t] = 1'b0;
        end
        if (hs) begin
            mv[int'(pend_tid) - int'(TB_BASE)]    = 1'b1;
            mline[int'(pend_tid) - int'(TB_BASE)] = pend_addr;
            last_tid = pend_tid;
            n_issue++;
        end
        if (hs || flush_i) pend_v = 1'b0;
        if (new_pend && free_i >= 0) begin
            pend_v    = 1'b1;
            pend_addr = line_a;
            pend_tid  = TB_BASE + TW'(free_i);
        end
        in_wait = (rd === 1'b1) && !flush_i;
        @(posedge clk_i);
        #1;
        if (rd === 1'b1 && q_addr.size() > 0) begin
            bus.fifo_valid = 1'b1;
            bus.fifo_addr  = q_addr.pop_front();
        end else begin
            bus.fifo_valid = 1'b0;
        end
    endtask

    task automatic wait_req(input string tag, input int max);
        int k = 0;
        while (bus.dcache_req_valid !== 1'b1 && k < max) begin
            tick();
            k++;
        end
        chk(tag, 64'(bus.dcache_req_valid), 64'(1));
    endtask

    task automatic wait_issued(input string tag, input int target, input int max);
        int k = 0;
        while (n_issue < target && k < max) begin
            tick();
            k++;
        end
        chk(tag, 64'(n_issue), 64'(target));
    endtask

    task automatic respond(input logic [TW-1:0] tid);
        bus.dcache_rsp_valid = 1'b1;
        bus.dcache_rsp_tid   = tid;
        tick();
        bus.dcache_rsp_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int i0;
        int k;
        n_checks = 0; n_fail = 0; n_issue = 0; n_drop = 0; n_read = 0;
        last_tid = '0; pend_addr = '0; pend_tid = '0;
        rst_ni = 1'b0; flush_i = 1'b0; lock_i = 1'b0;
        bus.fifo_valid = 1'b0; bus.fifo_addr = '0; bus.dcache_req_ready = 1'b0;
        bus.dcache_rsp_valid = 1'b0; bus.dcache_rsp_tid = '0;
        model_clear();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_fifo_read", 64'(bus.fifo_read), 64'(0));
        chk("rst_req_valid", 64'(bus.dcache_req_valid), 64'(0));
        chk("rst_req_addr", 64'(bus.dcache_req_addr), 64'(0));
        chk("rst_req_tid", 64'(bus.dcache_req_tid), 64'(0));
        chk("rst_drop", 64'(drop_o), 64'(0));
        chk("rst_cnt", 64'(inflight_cnt_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        rst_ni = 1'b1;

        // Single prefetch with ready held low for three cycles
        q_addr.push_back(40'h1234);
        wait_req("t1_req_valid", 12);
        chk("t1_addr", 64'(bus.dcache_req_addr), 64'h1200);
        chk("t1_tid", 64'(bus.dcache_req_tid), 64'h40);
        repeat (3) tick();
        bus.dcache_req_ready = 1'b1;
        tick();
        bus.dcache_req_ready = 1'b0;
        chk("t1_issued", 64'(n_issue), 64'(1));
        chk("t1_cnt", 64'(inflight_cnt_o), 64'(1));
        respond(7'h40);
        chk("t1_cnt_freed", 64'(inflight_cnt_o), 64'(0));

        // Empty queue: pop retried every third cycle, nothing issued or dropped
        r0 = n_read; d0 = n_drop; i0 = n_issue;
        repeat (9) tick();
        chk("t2_pop_retries", 64'(n_read - r0), 64'(3));
        chk("t2_no_drop", 64'(n_drop - d0), 64'(0));
        chk("t2_no_issue", 64'(n_issue - i0), 64'(0));

        // Duplicate of an in-flight line is dropped
        bus.dcache_req_ready = 1'b1;
        q_addr.push_back(40'h1234);
        wait_issued("t3_first_issue", n_issue + 1, 20);
        q_addr.push_back(40'h1238);
        d0 = n_drop; i0 = n_issue;
        repeat (8) tick();
        chk("t3_drop_once", 64'(n_drop - d0), 64'(1));
        chk("t3_no_issue", 64'(n_issue - i0), 64'(0));
        chk("t3_cnt", 64'(inflight_cnt_o), 64'(1));

        // Fill all slots, stall at full, free out of order, reuse the freed TID
        respond(7'h40);
        q_addr.push_back(40'h2000); q_addr.push_back(40'h2041);
        q_addr.push_back(40'h2080); q_addr.push_back(40'h20ff);
        wait_issued("t4_four_issued", n_issue + 4, 40);
        chk("t4_cnt_full", 64'(inflight_cnt_o), 64'(4));
        chk("t4_last_tid", 64'(last_tid), 64'h43);
        q_addr.push_back(40'h3000);
        r0 = n_read;
        repeat (10) tick();
        chk("t4_no_pop_full", 64'(n_read - r0), 64'(0));
        respond(7'h42);
        chk("t4_cnt_after_free", 64'(inflight_cnt_o), 64'(3));
        wait_issued("t4_reissue", n_issue + 1, 20);
        chk("t4_reused_tid", 64'(last_tid), 64'h42);
        respond(7'h05);
        chk("t4_bogus_low", 64'(inflight_cnt_o), 64'(4));
        respond(7'h44);
        chk("t4_bogus_high", 64'(inflight_cnt_o), 64'(4));
        for (int i = 0; i < int'(MAXI); i++) respond(TB_BASE + TW'(i));
        chk("t4_all_freed", 64'(inflight_cnt_o), 64'(0));

        // Flush while waiting for ready, then flush coinciding with ready
        bus.dcache_req_ready = 1'b0;
        q_addr.push_back(40'h5000);
        wait_req("t5_req_valid", 12);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t5_valid_dropped", 64'(bus.dcache_req_valid), 64'(0));
        chk("t5_cnt_unchanged", 64'(inflight_cnt_o), 64'(0));
        q_addr.push_back(40'h5040);
        wait_req("t5_req_valid2", 12);
        flush_i = 1'b1;
        bus.dcache_req_ready = 1'b1;
        tick();
        flush_i = 1'b0;
        bus.dcache_req_ready = 1'b0;
        chk("t5_hs_wins_cnt", 64'(inflight_cnt_o), 64'(1));
        chk("t5_hs_wins_tid", 64'(last_tid), 64'h40);

        // Lock holds the issuer in IDLE
        lock_i = 1'b1;
        k = 0;
        while (busy_o !== 1'b0 && k < 10) begin
            tick();
            k++;
        end
        chk("t6_idle_under_lock", 64'(busy_o), 64'(0));
        q_addr.push_back(40'h6000);
        r0 = n_read;
        repeat (10) tick();
        chk("t6_no_pop_locked", 64'(n_read - r0), 64'(0));
        lock_i = 1'b0;
        bus.dcache_req_ready = 1'b1;
        wait_issued("t6_issue_after_lock", n_issue + 1, 20);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(9) < 3 && q_addr.size() < 6)
                q_addr.push_back(40'h10000 + AW'($urandom_range(7)) * AW'(LB) + AW'($urandom_range(63)));
            bus.dcache_req_ready = ($urandom_range(1) == 1);
            lock_i               = ($urandom_range(9) == 0);
            flush_i              = ($urandom_range(29) == 0);
            bus.dcache_rsp_valid = ($urandom_range(4) == 0);
            bus.dcache_rsp_tid   = ($urandom_range(3) == 0) ? TW'($urandom_range(127))
                                                            : TB_BASE + TW'($urandom_range(MAXI - 1));
            tick();
        end
        flush_i = 1'b0; lock_i = 1'b0; bus.dcache_rsp_valid = 1'b0;

        // Drain queue and slots
        bus.dcache_req_ready = 1'b1;
        k = 0;
        while (!(q_addr.size() == 0 && !pend_v && model_cnt() == 0) && k < 300) begin
            bus.dcache_rsp_valid = 1'b0;
            for (int i = int'(MAXI) - 1; i >= 0; i--) begin
                if (mv[i]) begin
                    bus.dcache_rsp_valid = 1'b1;
                    bus.dcache_rsp_tid   = TB_BASE + TW'(i);
                end
            end
            tick();
            k++;
        end
        bus.dcache_rsp_valid = 1'b0;
        chk("drain_complete", 64'(q_addr.size() == 0 && !pend_v && model_cnt() == 0), 64'(1));
        tick();
        chk("drain_cnt", 64'(inflight_cnt_o), 64'(0));

        // Asynchronous reset in the middle of an issue
        q_addr.push_back(40'h7000);
        wait_issued("t7_slot_taken", n_issue + 1, 20);
        bus.dcache_req_ready = 1'b0;
        q_addr.push_back(40'h7040);
        wait_req("t7_req_valid", 12);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7_rst_req_valid", 64'(bus.dcache_req_valid), 64'(0));
        chk("t7_rst_req_addr", 64'(bus.dcache_req_addr), 64'(0));
        chk("t7_rst_req_tid", 64'(bus.dcache_req_tid), 64'(0));
        chk("t7_rst_cnt", 64'(inflight_cnt_o), 64'(0));
        chk("t7_rst_busy", 64'(busy_o), 64'(0));
        chk("t7_rst_fifo_read", 64'(bus.fifo_read), 64'(0));
        chk("t7_rst_drop", 64'(drop_o), 64'(0));
        model_clear();
        bus.fifo_valid = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hwpf_issuer.md
Name: hwpf_issuer

Overview:
- Drain side of the next-line prefetch request queue.
- Pops one prefetch request at a time from the queue, filters out duplicates of lines already in flight, allocates a prefetch transaction ID (TID) and issues a line-aligned request to the HPDcache request port with a valid/ready handshake.
- Tracks outstanding prefetches until the cache responds.
- Sits between the prefetch queue and the dcache arbiter inside the prefetcher.

Parameters:
- MAX_INFLIGHT, 4, number of outstanding prefetch slots (power of two, 2..16).
- ADDR_W, 40, physical address width.
- LINE_BYTES, 64, cache line size in bytes (power of two).
- TID_W, 7, transaction ID width.
- TID_BASE, 7'h40, first prefetch TID. Slot i uses TID_BASE+i. TID_BASE is a multiple of MAX_INFLIGHT, disjoint from CPU TIDs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  abort the pending (not yet accepted) request and return to IDLE.
- lock_i  in  1  CPU owns the cache port; no new pop is started.
- fifo_read_o  out  1  one-cycle pop pulse to the queue.
- fifo_valid_i  in  1  queue output valid; registered, meaningful only in the cycle after fifo_read_o.
- fifo_addr_i  in  ADDR_W  queue output address, same timing as fifo_valid_i.
- dcache_req_valid_o  out  1  prefetch request valid.
- dcache_req_ready_i  in  1  cache accepts the request.
- dcache_req_addr_o  out  ADDR_W  line-aligned address.
- dcache_req_tid_o  out  TID_W  allocated TID.
- dcache_rsp_valid_i  in  1  response valid.
- dcache_rsp_tid_i  in  TID_W  response TID.
- drop_o  out  1  one-cycle pulse: popped request dropped as a duplicate.
- inflight_cnt_o  out  $clog2(MAX_INFLIGHT)+1  number of occupied slots.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_ni=0):
  - FSM=IDLE.
  - All slots invalid; slot addresses 0.
  - All outputs 0: fifo_read_o, dcache_req_valid_o, dcache_req_addr_o, dcache_req_tid_o, drop_o, inflight_cnt_o, busy_o.
- FSM states: IDLE, POP, WAIT, ISSUE.
  - IDLE→POP: when !lock_i, !flush_i, and at least one slot is free.
  - POP: fifo_read_o=1 for exactly this cycle; next state WAIT.
  - WAIT: sample fifo_valid_i and fifo_addr_i.
    - fifo_valid_i=0 → IDLE (queue empty, no pulse).
    - Line address matches a valid slot → drop_o=1 this cycle, then IDLE.
    - Otherwise → ISSUE. On entry, latch line address = fifo_addr_i with the low log2(LINE_BYTES) bits zeroed, and reserve the lowest-index free slot.
  - ISSUE:
    - dcache_req_valid_o=1, with addr and TID held stable until dcache_req_ready_i=1.
    - On the handshake: mark the slot valid with its line address, then go to IDLE. One request per handshake.
    - lock_i has no effect once in ISSUE.
- Handshake rule: once valid is asserted it stays asserted until ready. The only exception is flush_i, which drops valid the next cycle with no slot allocated.
- Responses:
  - dcache_rsp_valid_i with TID in [TID_BASE, TID_BASE+MAX_INFLIGHT-1] and the matching slot valid frees that slot next cycle.
  - Any other TID, or a TID whose slot is already free, is ignored.
- Simultaneous events:
  - A response freeing slot k in the same cycle as an issue handshake on slot j: both take effect.
  - A response can free the reserved slot's neighbour but never the reserved slot itself, because the reserved slot is still invalid.
- Slot occupancy: inflight_cnt_o is the registered count of valid slots.
  - Max MAX_INFLIGHT.
  - At full, IDLE stalls: no pop occurs, so queue contents are preserved.
- Flush:
  - FSM→IDLE next cycle and drops any WAIT/ISSUE request.
  - An accepted (handshaken) request is never aborted.
  - Flush does not clear slots, so late responses still free them correctly.
  - A flush in the same cycle as a handshake: the handshake wins and the slot is allocated.
- Duplicate compare: on line address bits [ADDR_W-1:log2(LINE_BYTES)] only.
- Reset mid-operation: immediate return to reset values. Any request in flight is forgotten.

Test Plan:
- Single prefetch: reset, queue returns valid with addr 0x1234 → read pulse; two cycles later dcache_req_valid_o=1, addr=0x1200, tid=0x40; ready held 3 cycles low then high → one handshake, inflight_cnt_o=1; response tid 0x40 → cnt=0.
- Empty queue: fifo_valid_i=0 in WAIT → no dcache_req_valid_o, no drop_o, FSM returns IDLE and retries the pop after 1 cycle.
- Duplicate: slot holds line 0x1200 in flight, queue returns 0x1238 → drop_o pulses once, no request issued, cnt unchanged at 1.
- Full and out-of-order free: issue 4 lines with ready=1 → tids 0x40..0x43, cnt=4, fifo_read_o stays 0; respond tid 0x42 → cnt=3, next issue reuses tid 0x42; bogus tid 0x05 → ignored.
- Flush: flush_i while in ISSUE with ready=0 → valid drops next cycle, cnt unchanged; flush_i coinciding with ready=1 → slot allocated, cnt increments.
- Lock / reset: lock_i=1 in IDLE → no fifo_read_o for the whole lock window; rst_ni low mid-ISSUE → all outputs 0 asynchronously, cnt=0.
